// File: rtl/iic_slave.sv
// I2C target: decodes START/STOP/address/data on SCL/SDA and maps transfers onto a byte register port.
// Latency: bus edges seen 2+FILT_LEN clk after the pin; reg_wr_en 1 clk after the 8th filtered scl_rise.
// Backpressure: none; the host must accept reg_wr_en and answer reg_rd_en on the next clk (no clock stretching).
module iic_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         FILT_LEN = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_iic_scl,
    inout  wire        io_iic_sda,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_wr_en,
    output logic       o_reg_rd_en,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_stop_int
);

    // Counter only has to reach FILT_LEN-1: the sample that completes the run flips the level.
    localparam int            CW        = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_WR_BYTE  = 3'd3,
        S_WR_ACK   = 3'd4,
        S_RD_BYTE  = 3'd5,
        S_RD_ACK   = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    logic [1:0]    r_scl_sync;
    logic [1:0]    r_sda_sync;
    logic          r_scl_filt;
    logic          r_sda_filt;
    logic [CW-1:0] r_scl_cnt;
    logic [CW-1:0] r_sda_cnt;
    logic          r_scl_prev;
    logic          r_sda_prev;

    state_t        r_state;
    logic [3:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          r_rw;
    logic          r_first;
    logic          r_mack;
    logic          r_sda_low;
    logic [7:0]    r_reg_addr;
    logic [7:0]    r_reg_wdata;
    logic          r_wr_en;
    logic          r_rd_en;
    logic          r_busy;
    logic          r_stop_int;

    logic          w_scl_rise;
    logic          w_scl_fall;
    logic          w_sda_rise;
    logic          w_sda_fall;
    logic          w_start;
    logic          w_stop;
    logic [7:0]    w_byte;

    // Open-drain: only ever pull low, otherwise leave the bus to the pull-up.
    assign io_iic_sda  = r_sda_low ? 1'b0 : 1'bz;

    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_wr_en = r_wr_en;
    assign o_reg_rd_en = r_rd_en;
    assign o_busy      = r_busy;
    assign o_stop_int  = r_stop_int;

    // Two-flop synchronizers; preset high to match an idle bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_iic_scl};
            r_sda_sync <= {r_sda_sync[0], io_iic_sda};
        end
    end

    // SCL glitch filter: accept a new level only after FILT_LEN consecutive differing samples.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_filt <= 1'b1;
            r_scl_cnt  <= '0;
        end else if (r_scl_sync[1] == r_scl_filt) begin
            r_scl_cnt  <= '0;
        end else if (r_scl_cnt == FILT_LAST) begin
            r_scl_filt <= r_scl_sync[1];
            r_scl_cnt  <= '0;
        end else begin
            r_scl_cnt  <= r_scl_cnt + CW'(1);
        end
    end

    // SDA glitch filter, identical to SCL so both lines keep the same delay and ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sda_filt <= 1'b1;
            r_sda_cnt  <= '0;
        end else if (r_sda_sync[1] == r_sda_filt) begin
            r_sda_cnt  <= '0;
        end else if (r_sda_cnt == FILT_LAST) begin
            r_sda_filt <= r_sda_sync[1];
            r_sda_cnt  <= '0;
        end else begin
            r_sda_cnt  <= r_sda_cnt + CW'(1);
        end
    end

    // Previous filtered levels for single-cycle edge pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    assign w_scl_rise = r_scl_filt & ~r_scl_prev;
    assign w_scl_fall = ~r_scl_filt & r_scl_prev;
    assign w_sda_rise = r_sda_filt & ~r_sda_prev;
    assign w_sda_fall = ~r_sda_filt & r_sda_prev;
    assign w_start    = w_sda_fall & r_scl_filt;
    assign w_stop     = w_sda_rise & r_scl_filt;

    // Byte as it stands once the bit on the current scl_rise is included.
    assign w_byte     = {r_shift[6:0], r_sda_filt};

    // Protocol FSM: bus conditions first, then bit handling; all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_rw        <= 1'b0;
            r_first     <= 1'b0;
            r_mack      <= 1'b0;
            r_sda_low   <= 1'b0;
            r_reg_addr  <= 8'd0;
            r_reg_wdata <= 8'd0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_stop_int  <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_stop_int <= 1'b0;

            // Pointer advances in the cycle after the write strobe, so the host sees the target address.
            if (r_wr_en) begin
                r_reg_addr <= r_reg_addr + 8'd1;
            end

            // Host answered the read strobe: capture the byte and put its MSB on the bus.
            if (r_rd_en) begin
                r_shift   <= i_reg_rdata;
                r_sda_low <= ~i_reg_rdata[7];
            end

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 4'd0;
                r_sda_low <= 1'b0;
                r_busy    <= 1'b0;
            end else if (w_stop) begin
                r_state    <= S_IDLE;
                r_sda_low  <= 1'b0;
                r_busy     <= 1'b0;
                r_stop_int <= r_busy;
            end else begin
                case (r_state)
                    S_ADDR: begin
                        if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                if (r_shift[6:0] == DEV_ADDR) begin
                                    r_busy <= 1'b1;
                                    r_rw   <= r_sda_filt;
                                end else begin
                                    r_state <= S_IGNORE;
                                end
                            end
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_sda_low <= 1'b1;
                            r_state   <= S_ADDR_ACK;
                        end
                    end

                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_low <= 1'b0;
                            r_bit_cnt <= 4'd0;
                            if (r_rw) begin
                                r_rd_en <= 1'b1;
                                r_state <= S_RD_BYTE;
                            end else begin
                                r_first <= 1'b1;
                                r_state <= S_WR_BYTE;
                            end
                        end
                    end

                    S_WR_BYTE: begin
                        if (w_scl_rise && (r_bit_cnt != 4'd8)) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                if (r_first) begin
                                    r_reg_addr <= w_byte;
                                end else begin
                                    r_reg_wdata <= w_byte;
                                    r_wr_en     <= 1'b1;
                                end
                            end
                        end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
                            r_sda_low <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_WR_ACK;
                        end
                    end

                    S_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_low <= 1'b0;
                            r_first   <= 1'b0;
                            r_state   <= S_WR_BYTE;
                        end
                    end

                    S_RD_BYTE: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd7) begin
                                r_sda_low  <= 1'b0;
                                r_bit_cnt  <= 4'd0;
                                r_mack     <= 1'b0;
                                r_reg_addr <= r_reg_addr + 8'd1;
                                r_state    <= S_RD_ACK;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_sda_low <= ~r_shift[6];
                            end
                        end
                    end

                    S_RD_ACK: begin
                        if (w_scl_rise) begin
                            // Master NACK ends the read; stay off the bus until the next condition.
                            if (r_sda_filt) begin
                                r_state <= S_IGNORE;
                            end else begin
                                r_mack <= 1'b1;
                            end
                        end else if (w_scl_fall && r_mack) begin
                            r_rd_en   <= 1'b1;
                            r_bit_cnt <= 4'd0;
                            r_state   <= S_RD_BYTE;
                        end
                    end

                    S_IGNORE: begin
                        r_sda_low <= 1'b0;
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iic_slave.md
Name: iic_slave

Overview:
- I2C target (slave) for the same two-wire bus that iic_top drives as initiator.
- Lets the MCU's I2C master loop back to an on-chip target, and lets external masters access a byte-wide register window.
- Samples SCL/SDA on the system clock. Decodes START, STOP, address and data. Drives SDA open-drain for ACK and read data.
- Exposes a simple synchronous register port to a host-side register bank.

Parameters:
- DEV_ADDR, 7'h50, 7-bit bus address this target answers to.
- FILT_LEN, 3, consecutive equal synced samples required before an SCL/SDA level change is accepted (glitch filter).

Ports:
- clk  input  1  system clock, ≥16× SCL frequency.
- rst_n  input  1  asynchronous active-low reset.
- iic_scl  input  1  bus clock. Never driven; no clock stretching.
- iic_sda  inout  1  bus data. Driven 1'b0 when pulling low, otherwise 1'bz.
- reg_addr  output  8  current register pointer.
- reg_wdata  output  8  byte received from master.
- reg_wr_en  output  1  one-clk pulse: write reg_wdata to reg_addr.
- reg_rd_en  output  1  one-clk pulse: host must present the byte at reg_addr on reg_rdata by the next clk.
- reg_rdata  input  8  read data from host, sampled one clk after reg_rd_en.
- busy  output  1  high from an address-matched START until STOP or a new START.
- stop_int  output  1  one-clk pulse on STOP after an addressed transaction.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: reg_addr=0, reg_wdata=0, reg_wr_en=0, reg_rd_en=0, busy=0, stop_int=0.
  - SDA released (z). State=IDLE. Synchronizers and filters preset to 1.
- Input conditioning:
  - 2-flop synchronizer on SCL and SDA, then FILT_LEN filter.
  - scl_rise/scl_fall/sda_rise/sda_fall are one-clk pulses derived from the filtered levels.
- Bus conditions:
  - START = sda_fall while SCL=1.
  - STOP = sda_rise while SCL=1.
  - Both are detected in every state and take priority over bit processing.
  - START in any state (repeated START included): bit counter cleared, state=ADDR, SDA released. reg_addr is kept.
  - STOP in any state: state=IDLE, SDA released. busy drops the same clk. stop_int pulses if busy was 1.
- Bits: sampled on scl_rise. Our SDA output changes only on scl_fall. Bits are MSB first.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - If [7:1]==DEV_ADDR: set busy and rw=bit0. On the scl_fall after bit 8, drive SDA=0 and go to ADDR_ACK.
    - On mismatch: go to IGNORE.
  - ADDR_ACK: on the scl_fall ending the ACK clock:
    - rw=0: release SDA, go to WR_BYTE with first_byte=1.
    - rw=1: pulse reg_rd_en, go to RD_BYTE. Latch reg_rdata into the shift register the next clk, then drive its MSB.
  - WR_BYTE: shift 8 bits, drive ACK on the following scl_fall, go to WR_ACK.
    - If first_byte: reg_addr <= byte.
    - Else: reg_wdata <= byte. reg_wr_en pulses on the clk after the 8th scl_rise. reg_addr increments (mod 256) after the pulse.
  - WR_ACK: release SDA on scl_fall, return to WR_BYTE with first_byte=0.
  - RD_BYTE: shift out on each scl_fall. After 8 bits, release SDA and go to RD_ACK. reg_addr increments (mod 256) after the 8th bit.
  - RD_ACK: sample master ACK on scl_rise.
    - SDA=0 (ACK): pulse reg_rd_en on the next scl_fall and return to RD_BYTE.
    - SDA=1 (NACK): go to IGNORE, SDA stays released.
  - IGNORE: SDA released. Wait for START or STOP.
- Boundaries:
  - reg_addr wraps 8'hFF→8'h00 in both directions of transfer.
  - STOP directly after the address ACK: no reg_wr_en.
  - STOP mid-byte: partial byte discarded, no reg_wr_en.
  - General-call address 7'h00 is not acknowledged.
  - Reset mid-transaction releases SDA immediately (async).
- Latency:
  - reg_wr_en occurs 1 clk after the scl_rise of bit 8 (post-filter, i.e. 2+FILT_LEN clk after the pin edge).
  - The ACK/data SDA drive starts 1 clk after the filtered scl_fall.

Test Plan:
- Write: START, 0xA0, 0x10, 0x55, 0xAA, STOP.
  - All four bytes ACKed.
  - reg_wr_en pulses twice: (0x10,0x55) then (0x11,0xAA).
  - Final reg_addr=0x12. stop_int pulses once.
- Read with repeated START: START, 0xA0, 0x20, Sr, 0xA1, read 3 bytes (ACK, ACK, NACK), STOP.
  - reg_rd_en fires at 0x20/0x21/0x22. Host data 0x11/0x22/0x33 appears on SDA MSB-first.
  - SDA released after NACK.
- Address mismatch: START, 0xB0, 0x01, STOP.
  - No ACK (SDA stays z throughout).
  - No reg_wr_en, busy never rises, no stop_int.
- Pointer wrap: write pointer 0xFF, then data 0x01, 0x02.
  - Writes land at 0xFF then 0x00. reg_addr ends at 0x01.
- Abort and glitch:
  - STOP after 4 bits of a data byte: no write, state IDLE.
  - 1-clk SCL glitch during IDLE (FILT_LEN=3): no edge detected, no state change.
- Reset mid-read: rst_n low while driving SDA=0.
  - SDA goes z in the same cycle. All outputs return to their reset values.
